serial_parity_tx: RTL

Serial transmitter that pairs with the odd-ones parity detector on a one-bit serial link. It accepts a parallel word over a valid/ready handshake and shifts it out LSB-first, one bit per clock. After the last data bit it appends one parity bit, selectable odd or even. Frames are marked with ser_valid and ser_last so the downstream checker and bench can delimit them.

---
 rtl/parity_pkg.sv | 25 ++
 rtl/parity_accum.sv | 30 +++
 rtl/serial_parity_tx.sv | 119 +++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared encodings for the serial parity transmitter and detector
package parity_pkg;

  // Transmitter frame sequencing
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } tx_state_e;

  localparam logic PARITY_ODD  = 1'b1;
  localparam logic PARITY_EVEN = 1'b0;

  // Odd-ones detector state: tracks whether an odd number of ones has been seen
  typedef enum logic {
    DET_EVEN = 1'b0,
    DET_ODD  = 1'b1
  } det_state_e;

  // Turns the XOR of the data ones into the transmitted parity bit
  function automatic logic parity_bit(input logic ones_xor, input logic odd_mode);
    return ones_xor ^ odd_mode;
  endfunction

endpackage

// File: rtl/parity_accum.sv
// rtl/parity_accum.sv - running XOR of a serial bit stream with clear and enable
module parity_accum (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  input  logic bit_in,
  output logic parity_q
);

  logic parity_d;

  // clear restarts the sum; a bit enabled together with clear is the first bit counted
  always_comb begin
    parity_d = clear ? 1'b0 : parity_q;
    if (enable) begin
      parity_d = parity_d ^ bit_in;
    end
  end

  // accumulator register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

endmodule

// File: rtl/serial_parity_tx.sv
// rtl/serial_parity_tx.sv - LSB-first serialiser that appends one odd/even parity bit per word
module serial_parity_tx #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              busy
);
  import parity_pkg::*;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] shift_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_valid_q, ser_valid_d;
  logic              ser_last_q, ser_last_d;
  logic              data_ready_q, data_ready_d;
  logic              acc_clear, acc_en, acc_bit, acc_q;
  logic              take;

  assign take      = data_valid && data_ready_q;
  assign shift_nxt = shift_q >> 1;

  // Outputs are registered: each edge computes the bit the line shows next cycle.
  // cnt_q counts bits already presented in the current frame.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;
    acc_clear   = 1'b0;
    acc_en      = 1'b0;
    acc_bit     = 1'b0;
    case (state_q)
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          state_d     = PARITY;
          cnt_d       = '0;
          ser_out_d   = parity_bit(acc_q, ODD_PARITY);
          ser_valid_d = 1'b1;
          ser_last_d  = 1'b1;
        end else begin
          shift_d     = shift_nxt;
          cnt_d       = cnt_q + CNT_W'(1);
          ser_out_d   = shift_nxt[0];
          ser_valid_d = 1'b1;
          acc_en      = 1'b1;
          acc_bit     = shift_nxt[0];
        end
      end
      default: begin
        // IDLE and PARITY both accept a word; accepting in PARITY chains frames with no gap
        if (take) begin
          state_d     = DATA;
          shift_d     = data_in;
          cnt_d       = CNT_W'(1);
          ser_out_d   = data_in[0];
          ser_valid_d = 1'b1;
          acc_clear   = 1'b1;
          acc_en      = 1'b1;
          acc_bit     = data_in[0];
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    data_ready_d = (state_d == IDLE) || (state_d == PARITY);
  end

  // state, datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      ser_last_q   <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      ser_last_q   <= ser_last_d;
      data_ready_q <= data_ready_d;
    end
  end

  parity_accum u_accum (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (acc_clear),
    .enable   (acc_en),
    .bit_in   (acc_bit),
    .parity_q (acc_q)
  );

  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign ser_last   = ser_last_q;
  assign data_ready = data_ready_q;
  assign busy       = (state_q != IDLE);

endmodule
